mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master to one-slave memory arbiter. It merges the core's instruction-fetch port (imem) and load/store port (dmem) onto a single unified memory port, so a single-port SRAM or bus can serve a `riscv_core` instance. It sits between the core's imem/dmem valid/ready interfaces and the memory.

Arbitration rules:
- dmem has fixed priority.
- A bounded-streak rule guarantees that fetch cannot be starved by back-to-back loads/stores.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- MAX_DMEM_STREAK, 4, maximum consecutive dmem grants while imem is waiting; range 1..15

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- imem_valid_i  in  1  fetch request
- imem_ready_o  out  1  fetch transfer completes this cycle
- imem_addr_i  in  ADDR_WIDTH  fetch address
- imem_wdata_i  in  DATA_WIDTH  fetch write data
- imem_we_i  in  4  fetch byte write enables
- imem_rdata_o  out  DATA_WIDTH  fetch read data
- dmem_valid_i, dmem_ready_o, dmem_addr_i, dmem_wdata_i, dmem_we_i, dmem_rdata_o  same widths and directions as the imem_* group, for load/store
- mem_valid_o  out  1  request to memory
- mem_ready_i  in  1  memory completes transfer
- mem_addr_o  out  ADDR_WIDTH  muxed address
- mem_wdata_o  out  DATA_WIDTH  muxed write data
- mem_we_o  out  4  muxed byte enables
- mem_rdata_i  in  DATA_WIDTH  memory read data
- grant_o  out  2  one-hot owner, {dmem, imem}; 2'b00 in IDLE

## Operation
State machine:
- States: IDLE, GNT_I, GNT_D. The state is registered, and grant_o decodes it directly.

IDLE:
- mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o are all 0.
- Both ready_o outputs are 0.
- Arbitration, evaluated on the current cycle's valids:
  - dmem only → GNT_D.
  - imem only → GNT_I.
  - both, and streak < MAX_DMEM_STREAK → GNT_D.
  - both, and streak == MAX_DMEM_STREAK → GNT_I.
  - neither → stay in IDLE.

GNT_x:
- mem_* is driven combinationally from owner x's addr/wdata/we.
- mem_valid_o = x_valid_i.
- x_ready_o = mem_ready_i & x_valid_i.
- The non-owner's ready_o is 0.
- When mem_ready_i & x_valid_i → IDLE.
- If x_valid_i is 0 (requester abort) → IDLE next cycle. No transfer occurs. mem_ready_i is ignored while mem_valid_o = 0.

Read data:
- mem_rdata_i is broadcast to both rdata outputs unregistered.
- It is meaningful only in the cycle where that port's ready_o = 1.

Streak counter (4 bits):
- On entering GNT_D: increments only if imem_valid_i was 1 at that decision; otherwise cleared to 0.
- On entering GNT_I: cleared to 0.
- Saturates at MAX_DMEM_STREAK.

Requester contract:
- Each requester holds valid, addr, wdata and we stable until its ready.
- The arbiter does not latch request fields.

## Timing
Reset values (rst_n low, asynchronous):
- state = IDLE, streak = 0, grant_o = 0.
- mem_valid_o = 0, imem_ready_o = 0, dmem_ready_o = 0.
- mem_addr_o, mem_wdata_o, mem_we_o = 0.

Latency and throughput:
- A request raised in cycle N while in IDLE is granted in cycle N+1, with mem_valid_o = 1 in N+1.
- With a zero-wait memory (mem_ready_i = 1), ready_o rises in N+1 and the arbiter returns to IDLE in N+2.
- Peak throughput is therefore one transfer per 2 cycles.
- Each memory wait cycle adds exactly one cycle.

Boundary conditions:
- Simultaneous valids: resolved only in IDLE. No preemption once a grant is given, even if the other port raises valid.
- The arbiter always passes through IDLE between transfers, so each transfer is arbitrated independently.
- Reset mid-grant: returns to IDLE immediately. Any in-flight memory transfer is abandoned; the memory must also be reset.
- No combinational path from mem_ready_i to mem_valid_o.
- There is a combinational path from mem_ready_i to ready_o, and from mem_rdata_i to rdata_o.

## Test plan
- Single fetch, zero-wait: imem_valid_i = 1, addr 0x100, in cycle 0 → grant_o = 01 and mem_addr_o = 0x100 in cycle 1, imem_ready_o = 1 in cycle 1, grant_o = 00 in cycle 2.
- Contention, MAX_DMEM_STREAK = 2, both valid continuously, each dmem request re-raised after ready → grant order D, D, I, D, D, I. Streak is cleared to 0 after each I grant.
- Wait states: dmem store (we = 4'hF, wdata 0xDEADBEEF) with mem_ready_i low for 3 cycles → mem_valid_o held 4 cycles with constant wdata, dmem_ready_o pulses once in the 4th, imem_ready_o stays 0 throughout.
- Abort: GNT_I entered, then imem_valid_i drops before mem_ready_i → next cycle is IDLE with mem_valid_o = 0. A mem_ready_i pulse that arrives while in IDLE produces no ready_o.
- Reset mid-grant: rst_n low while in GNT_D with mem_ready_i = 0 → all outputs 0 asynchronously. After release, a dmem request is granted fresh with streak = 0.
- Read data: in GNT_I, mem_rdata_i = 0x12345678 with mem_ready_i = 1 → imem_rdata_o = 0x12345678 and imem_ready_o = 1 in the same cycle, dmem_ready_o = 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master (fetch, load/store) to one-slave memory arbiter. Load/store has fixed priority,
// bounded by a streak counter so a waiting fetch is granted after MAX_DMEM_STREAK dmem wins.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_DMEM_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  imem_valid_i,
  output logic                  imem_ready_o,
  input  logic [ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [DATA_WIDTH-1:0] imem_wdata_i,
  input  logic [3:0]            imem_we_i,
  output logic [DATA_WIDTH-1:0] imem_rdata_o,
  input  logic                  dmem_valid_i,
  output logic                  dmem_ready_o,
  input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
  input  logic [3:0]            dmem_we_i,
  output logic [DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_we_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [1:0]            grant_o
);

  localparam logic [3:0] MaxStreak = 4'(MAX_DMEM_STREAK);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e     state_q, state_d;
  logic [3:0] streak_q, streak_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    unique case (state_q)
      StIdle: begin
        if (dmem_valid_i && (!imem_valid_i || (streak_q < MaxStreak))) begin
          state_d = StGntD;
          // Only counts wins that made fetch wait; streak_q < MaxStreak here, so it saturates.
          streak_d = imem_valid_i ? streak_q + 4'd1 : 4'd0;
        end else if (imem_valid_i) begin
          state_d  = StGntI;
          streak_d = '0;
        end
      end
      StGntI: if (!imem_valid_i || mem_ready_i) state_d = StIdle;
      StGntD: if (!dmem_valid_i || mem_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_valid_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_we_o     = '0;
    imem_ready_o = 1'b0;
    dmem_ready_o = 1'b0;
    grant_o      = 2'b00;
    unique case (state_q)
      StGntI: begin
        grant_o      = 2'b01;
        mem_valid_o  = imem_valid_i;
        mem_addr_o   = imem_addr_i;
        mem_wdata_o  = imem_wdata_i;
        mem_we_o     = imem_we_i;
        imem_ready_o = mem_ready_i & imem_valid_i;
      end
      StGntD: begin
        grant_o      = 2'b10;
        mem_valid_o  = dmem_valid_i;
        mem_addr_o   = dmem_addr_i;
        mem_wdata_o  = dmem_wdata_i;
        mem_we_o     = dmem_we_i;
        dmem_ready_o = mem_ready_i & dmem_valid_i;
      end
      default: ;
    endcase
  end

  assign imem_rdata_o = mem_rdata_i;
  assign dmem_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level owner/streak model checked every cycle,
// plus literal expectations for each scenario.
module tb_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned MAX = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          imem_valid, imem_ready;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata, imem_rdata;
  logic [3:0]    imem_we;
  logic          dmem_valid, dmem_ready;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic [3:0]    dmem_we;
  logic          mem_valid, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_we;
  logic [1:0]    grant;

  mem_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .MAX_DMEM_STREAK(MAX)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_valid_i(imem_valid),
    .imem_ready_o(imem_ready),
    .imem_addr_i (imem_addr),
    .imem_wdata_i(imem_wdata),
    .imem_we_i   (imem_we),
    .imem_rdata_o(imem_rdata),
    .dmem_valid_i(dmem_valid),
    .dmem_ready_o(dmem_ready),
    .dmem_addr_i (dmem_addr),
    .dmem_wdata_i(dmem_wdata),
    .dmem_we_i   (dmem_we),
    .dmem_rdata_o(dmem_rdata),
    .mem_valid_o (mem_valid),
    .mem_ready_i (mem_ready),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_we_o    (mem_we),
    .mem_rdata_i (mem_rdata),
    .grant_o     (grant)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who currently owns the memory (0 none, 1 fetch, 2 load/store) and how many
  // load/store wins in a row have made a fetch wait.
  int owner = 0;
  int dwins = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = 0;
      dwins = 0;
    end else if (owner == 0) begin
      if (dmem_valid && !(imem_valid && dwins >= int'(MAX))) begin
        owner = 2;
        dwins = imem_valid ? dwins + 1 : 0;
      end else if (imem_valid) begin
        owner = 1;
        dwins = 0;
      end
    end else if (owner == 1) begin
      if (!imem_valid || mem_ready) owner = 0;
    end else begin
      if (!dmem_valid || mem_ready) owner = 0;
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic          e_valid, e_ir, e_dr;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
      logic [3:0]    e_we;
      logic [1:0]    e_gnt;
      e_valid = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
      e_addr = '0; e_wdata = '0; e_we = '0; e_gnt = 2'b00;
      if (rst_n && owner == 1) begin
        e_gnt = 2'b01; e_valid = imem_valid; e_addr = imem_addr;
        e_wdata = imem_wdata; e_we = imem_we; e_ir = imem_valid & mem_ready;
      end else if (rst_n && owner == 2) begin
        e_gnt = 2'b10; e_valid = dmem_valid; e_addr = dmem_addr;
        e_wdata = dmem_wdata; e_we = dmem_we; e_dr = dmem_valid & mem_ready;
      end
      check("m_grant", grant, e_gnt);
      check("m_mem_valid", mem_valid, e_valid);
      check("m_mem_addr", mem_addr, e_addr);
      check("m_mem_wdata", mem_wdata, e_wdata);
      check("m_mem_we", mem_we, e_we);
      check("m_imem_ready", imem_ready, e_ir);
      check("m_dmem_ready", dmem_ready, e_dr);
      check("m_imem_rdata", imem_rdata, mem_rdata);
      check("m_dmem_rdata", dmem_rdata, mem_rdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  logic [1:0] log_q[$];
  logic [1:0] exp_order [6];
  logic [1:0] exp_rst [3];
  int         dready_cnt;

  initial begin
    imem_valid = 0; imem_addr = '0; imem_wdata = '0; imem_we = '0;
    dmem_valid = 0; dmem_addr = '0; dmem_wdata = '0; dmem_we = '0;
    mem_ready = 0; mem_rdata = '0;
    exp_order = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
    exp_rst   = '{2'b10, 2'b10, 2'b01};

    #3;
    check("rst_grant", grant, 2'b00);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_imem_ready", imem_ready, 1'b0);
    check("rst_dmem_ready", dmem_ready, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    tick();
    rst_n = 1; chk_en = 1;

    // Single fetch, zero-wait.
    imem_valid = 1; imem_addr = 32'h100; mem_ready = 1;
    mid(); check("f_idle_grant", grant, 2'b00); check("f_idle_valid", mem_valid, 1'b0);
    tick();
    mid(); check("f_grant", grant, 2'b01); check("f_addr", mem_addr, 32'h100);
    check("f_ready", imem_ready, 1'b1);
    tick(); imem_valid = 0; imem_addr = '0;
    mid(); check("f_back_idle", grant, 2'b00);

    // Contention with continuous valids.
    tick();
    imem_valid = 1; imem_addr = 32'h104; dmem_valid = 1; dmem_addr = 32'h204; mem_ready = 1;
    log_q.delete();
    repeat (12) begin
      mid(); if (grant != 2'b00) log_q.push_back(grant);
      tick();
    end
    imem_valid = 0; dmem_valid = 0;
    check("c_count", 64'(log_q.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      check("c_order", (i < log_q.size()) ? log_q[i] : 2'b11, exp_order[i]);

    // Store with three wait cycles; fetch raised mid-transfer must not preempt.
    dmem_valid = 1; dmem_addr = 32'h200; dmem_wdata = 32'hDEADBEEF; dmem_we = 4'hF;
    mem_ready = 0;
    mid();
    tick();
    dready_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      mid();
      check("w_valid", mem_valid, 1'b1);
      check("w_wdata", mem_wdata, 32'hDEADBEEF);
      check("w_grant", grant, 2'b10);
      check("w_iready", imem_ready, 1'b0);
      check("w_dready", dmem_ready, 64'(k == 3));
      dready_cnt += int'(dmem_ready);
      tick();
      if (k == 0) begin imem_valid = 1; imem_addr = 32'h108; end
      if (k == 2) mem_ready = 1;
    end
    dmem_valid = 0; dmem_wdata = '0; dmem_we = '0;
    check("w_pulses", 64'(dready_cnt), 64'd1);
    mid(); check("w_idle", grant, 2'b00);
    tick();
    mid(); check("w_fetch_grant", grant, 2'b01); check("w_fetch_addr", mem_addr, 32'h108);
    tick(); imem_valid = 0;

    // Abort: fetch drops valid before the memory answers.
    mem_ready = 0; imem_valid = 1; imem_addr = 32'h10C;
    mid();
    tick();
    mid(); check("a_grant", grant, 2'b01); check("a_valid", mem_valid, 1'b1);
    check("a_iready", imem_ready, 1'b0);
    tick(); imem_valid = 0;
    mid(); check("a_valid_drop", mem_valid, 1'b0);
    tick(); mem_ready = 1;
    mid(); check("a_idle", grant, 2'b00); check("a_no_iready", imem_ready, 1'b0);
    check("a_no_dready", dmem_ready, 1'b0);
    tick(); mem_ready = 0;

    // Reset mid-grant, then streak must restart from zero.
    imem_valid = 1; imem_addr = 32'h110; dmem_valid = 1; dmem_addr = 32'h300;
    mid();
    tick();
    mid(); check("r_grant_pre", grant, 2'b10);
    #2; rst_n = 0;
    #1;
    check("r_grant", grant, 2'b00); check("r_valid", mem_valid, 1'b0);
    check("r_addr", mem_addr, 32'h0);
    check("r_iready", imem_ready, 1'b0); check("r_dready", dmem_ready, 1'b0);
    tick(); rst_n = 1; mem_ready = 1;
    log_q.delete();
    repeat (6) begin
      mid(); if (grant != 2'b00) log_q.push_back(grant);
      tick();
    end
    imem_valid = 0; dmem_valid = 0;
    check("r_count", 64'(log_q.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      check("r_order", (i < log_q.size()) ? log_q[i] : 2'b11, exp_rst[i]);

    // Read data broadcast in the ready cycle.
    imem_valid = 1; imem_addr = 32'h114; mem_rdata = 32'h12345678;
    mid();
    tick();
    mid(); check("d_rdata", imem_rdata, 32'h12345678); check("d_iready", imem_ready, 1'b1);
    check("d_dready", dmem_ready, 1'b0);
    tick(); imem_valid = 0;
    mid();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
